// File: rtl/hdlc_tx_bank_sched.sv
// hdlc_tx_bank_sched
//   Ping-pong scheduler for the HDLC transmit RAM. The RAM holds two banks of
//   2^ADDR_W bytes. The host fills wr_bank and commits it with a byte length.
//   The read side drains full banks in order: start pulse, opening-flag
//   window, one RAM read every BYTE_CYC cycles, then a closing-flag window.
//   The bank is then freed and the read side moves to the other bank.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   commit_vld_i/len_i  host commit of wr_bank with a length (1..2^ADDR_W)
//   commit_rdy_o        wr_bank is free, a commit will be accepted
//   wr_bank_o           bank the host writes (host RAM address MSB)
//   err_len_o           pulse: commit rejected for an illegal length
//   tx_abort_i          abandon the frame in flight
//   tx_start_o          pulse at frame start
//   tx_flag_o           opening-flag window
//   rd_en_o, rd_addr_o  RAM read strobe and {rd_bank, offset}; addr is 0 when idle
//   byte_vld_o          rd_en_o delayed one cycle (RAM read latency)
//   tx_close_o          closing-flag window
//   frame_done_o        pulse after a normally completed frame
//   frames_sent_o       count of normally completed frames (wraps)
module hdlc_tx_bank_sched #(
  parameter int ADDR_W   = 8,
  parameter int FLAG_CYC = 84,
  parameter int BYTE_CYC = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              commit_vld_i,
  input  logic [ADDR_W:0]   commit_len_i,
  output logic              commit_rdy_o,
  output logic              wr_bank_o,
  output logic              err_len_o,
  input  logic              tx_abort_i,
  output logic              tx_start_o,
  output logic              tx_flag_o,
  output logic              rd_en_o,
  output logic [ADDR_W:0]   rd_addr_o,
  output logic              byte_vld_o,
  output logic              tx_close_o,
  output logic              frame_done_o,
  output logic [15:0]       frames_sent_o
);

  localparam int TMAX = (FLAG_CYC > BYTE_CYC) ? FLAG_CYC : BYTE_CYC;
  localparam int TW   = $clog2(TMAX);
  localparam logic [TW-1:0]   FLAG_LAST = TW'(FLAG_CYC - 1);
  localparam logic [TW-1:0]   BYTE_LAST = TW'(BYTE_CYC - 1);
  localparam logic [TW-1:0]   T_ONE     = TW'(1);
  localparam logic [ADDR_W:0] LEN_MAX   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] LEN_ONE   = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {IDLE, FLAG, DATA, CLOSE} state_e;

  state_e                 state_q;
  logic                   wr_bank_q, rd_bank_q;
  logic [1:0]             full_q, full_d;
  logic [1:0][ADDR_W:0]   len_q;
  logic [ADDR_W-1:0]      off_q;
  logic [TW-1:0]          timer_q;
  logic                   err_len_q, tx_start_q, tx_flag_q, rd_en_q, byte_vld_q;
  logic                   tx_close_q, frame_done_q;
  logic [ADDR_W:0]        rd_addr_q;
  logic [15:0]            frames_sent_q;

  logic len_ok, accept, reject, free;

  // Write-side accept/reject and the bank-free event from the read side.
  // A free always targets rd_bank while a commit needs wr_bank empty, so
  // both can land in the same cycle without conflict.
  always_comb begin
    commit_rdy_o = ~full_q[wr_bank_q];
    len_ok       = (commit_len_i != '0) && (commit_len_i <= LEN_MAX);
    accept       = commit_vld_i & commit_rdy_o & len_ok;
    reject       = commit_vld_i & commit_rdy_o & ~len_ok;
    free         = (state_q != IDLE) &
                   (tx_abort_i | ((state_q == CLOSE) && (timer_q == BYTE_LAST)));
    full_d = full_q;
    if (accept) full_d[wr_bank_q] = 1'b1;
    if (free)   full_d[rd_bank_q] = 1'b0;
  end

  // Bank bookkeeping
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      full_q    <= '0;
      len_q     <= '0;
      err_len_q <= 1'b0;
    end else begin
      full_q    <= full_d;
      err_len_q <= reject;
      if (accept) begin
        len_q[wr_bank_q] <= commit_len_i;
        wr_bank_q        <= ~wr_bank_q;
      end
      if (free) rd_bank_q <= ~rd_bank_q;
    end
  end

  // Read-side sequencer; every output is a flop loaded on the transition
  // into the cycle where it must be seen.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      off_q         <= '0;
      timer_q       <= '0;
      tx_start_q    <= 1'b0;
      tx_flag_q     <= 1'b0;
      rd_en_q       <= 1'b0;
      rd_addr_q     <= '0;
      byte_vld_q    <= 1'b0;
      tx_close_q    <= 1'b0;
      frame_done_q  <= 1'b0;
      frames_sent_q <= '0;
    end else begin
      tx_start_q   <= 1'b0;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      frame_done_q <= 1'b0;
      byte_vld_q   <= rd_en_q;
      if (state_q != IDLE && tx_abort_i) begin
        state_q    <= IDLE;
        timer_q    <= '0;
        tx_flag_q  <= 1'b0;
        tx_close_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: if (full_q[rd_bank_q]) begin
            state_q    <= FLAG;
            timer_q    <= '0;
            tx_start_q <= 1'b1;
            tx_flag_q  <= 1'b1;
          end
          FLAG: if (timer_q == FLAG_LAST) begin
            state_q   <= DATA;
            timer_q   <= '0;
            off_q     <= '0;
            tx_flag_q <= 1'b0;
            rd_en_q   <= 1'b1;
            rd_addr_q <= {rd_bank_q, {ADDR_W{1'b0}}};
          end else timer_q <= timer_q + T_ONE;
          DATA: if (timer_q == BYTE_LAST) begin
            timer_q <= '0;
            if ({1'b0, off_q} == len_q[rd_bank_q] - LEN_ONE) begin
              state_q    <= CLOSE;
              tx_close_q <= 1'b1;
            end else begin
              off_q     <= off_q + 1'b1;
              rd_en_q   <= 1'b1;
              rd_addr_q <= {rd_bank_q, off_q + 1'b1};
            end
          end else timer_q <= timer_q + T_ONE;
          CLOSE: if (timer_q == BYTE_LAST) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            tx_close_q    <= 1'b0;
            frame_done_q  <= 1'b1;
            frames_sent_q <= frames_sent_q + 16'd1;
          end else timer_q <= timer_q + T_ONE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign wr_bank_o     = wr_bank_q;
  assign err_len_o     = err_len_q;
  assign tx_start_o    = tx_start_q;
  assign tx_flag_o     = tx_flag_q;
  assign rd_en_o       = rd_en_q;
  assign rd_addr_o     = rd_addr_q;
  assign byte_vld_o    = byte_vld_q;
  assign tx_close_o    = tx_close_q;
  assign frame_done_o  = frame_done_q;
  assign frames_sent_o = frames_sent_q;

endmodule
